multiply_seq_ctrl: RTL
======================

Name: multiply_seq_ctrl

Overview:
- Sequential shift-and-add multiply controller.
- Accepts an operand pair over a valid/ready handshake and iterates the multiplier over DATA_WIDTH slowClk cycles.
- Presents the unsigned 2*DATA_WIDTH product over a valid/ready output handshake.
- Sits upstream of the multiply result register in the slow clock domain. It sequences when that register's input is meaningful.

Parameters:
- DATA_WIDTH, 4: operand width in bits. Product is 2*DATA_WIDTH. Legal range 2..32.

Ports:
- slowClk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on slowClk rising edge.
- inValid  input  1  operand pair on aIn/bIn is valid.
- inReady  output  1  controller can accept an operand pair.
- aIn  input  DATA_WIDTH  multiplicand, unsigned.
- bIn  input  DATA_WIDTH  multiplier, unsigned.
- outValid  output  1  product is valid and held stable.
- outReady  input  1  downstream accepts product.
- product  output  2*DATA_WIDTH  unsigned result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Interface: one clock (slowClk). Reset is synchronous and active-high.
- Reset values: state=IDLE, inReady=1, outValid=0, busy=0, product=0. Internal accumulator, shifted multiplicand, multiplier and iteration counter are all cleared.
- FSM has three states: IDLE, CALC, DONE. All outputs are decoded from registered state or registered datapath; no combinational input-to-output paths.
- IDLE:
  - inReady=1, busy=0.
  - On inValid&inReady at a rising edge:
    - mcand <= zero-extended aIn (2*DATA_WIDTH bits).
    - mplier <= bIn.
    - acc <= 0, cnt <= 0, state <= CALC.
- CALC (one iteration per edge):
  - If mplier[0]=1: acc <= acc + mcand. The addition is modulo 2^(2*DATA_WIDTH) and never overflows for unsigned operands.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == DATA_WIDTH-1 at the edge, state <= DONE.
  - inReady=0, busy=1. inValid is ignored.
- DONE:
  - outValid=1, product=acc, held stable while outReady=0 for any number of cycles.
  - On outValid&outReady at an edge, state <= IDLE. outValid is low from the next cycle.
  - inReady=0 in DONE, so there is no accept-while-draining overlap. Minimum spacing between accepts is DATA_WIDTH+2 cycles.
- Latency:
  - Acceptance edge = edge 0. outValid is first high after edge DATA_WIDTH.
  - With DATA_WIDTH=4: accept at edge 0, outValid high after edge 4.
- product in IDLE and CALC:
  - Holds the last delivered result, which is 0 after reset.
  - Updates only on the CALC->DONE transition.
- Reset mid-operation: reset high in any state forces the reset values at that edge. The in-flight transaction is dropped and no outValid is produced. Reset has priority over every handshake.
- inValid while inReady=0: no effect. Upstream must hold aIn/bIn until accepted.
- Operands of zero: still take the full DATA_WIDTH iterations (without the optional feature); product=0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in CALC, the transition to DONE also occurs at the edge where the post-shift multiplier (mplier>>1) is zero.
  - Latency = max(1, index of the highest set bit of bIn + 1) cycles.
  - bIn=0 completes in 1 CALC cycle with product 0.
  - The result value is identical to the full-iteration result.
- Undefined: fixed latency of DATA_WIDTH CALC cycles regardless of operands.

Test Plan:
- DATA_WIDTH=4: aIn=3, bIn=5, outReady=1 -> outValid high exactly 4 edges after acceptance, product=8'd15; inReady returns to 1 one cycle after the output handshake.
- aIn=15, bIn=15 -> product=8'd225 with no truncation. Also aIn=15, bIn=1 -> product=15.
- aIn=0, bIn=9, then aIn=9, bIn=0 -> product=0 both times.
  - Without MULT_EARLY_TERM_EN: both latencies are 4.
  - With it: latencies are 4 and 1 respectively.
- Backpressure: aIn=6, bIn=7, outReady held 0 for 5 cycles after outValid -> outValid and product=42 stable throughout; inReady=0; inValid pulses are ignored; completes on outReady=1.
- Reset asserted on the 2nd CALC cycle of aIn=7, bIn=7 -> next cycle state IDLE, outValid=0, product=0, inReady=1. A subsequent aIn=2, bIn=3 yields 6 with normal latency.
- Back-to-back: inValid held high with a stream of 8 random pairs, outReady=1 -> every product equals aIn*bIn; accept spacing is exactly DATA_WIDTH+2 cycles; no pair is dropped or duplicated.

Source files
------------

// File: rtl/multiply_seq_ctrl_if.sv
// Handshake bundle for multiply_seq_ctrl: operand input channel,
// product output channel and the busy status flag.
// The master side (upstream/downstream logic) drives operands and outReady;
// the slave side (the controller) drives inReady, outValid, product and busy.
interface multiply_seq_ctrl_if #(
  parameter int DATA_WIDTH = 4
);
  logic                      inValid;
  logic                      inReady;
  logic [DATA_WIDTH-1:0]     aIn;
  logic [DATA_WIDTH-1:0]     bIn;
  logic                      outValid;
  logic                      outReady;
  logic [2*DATA_WIDTH-1:0]   product;
  logic                      busy;

  modport master (
    output inValid, aIn, bIn, outReady,
    input  inReady, outValid, product, busy
  );

  modport slave (
    input  inValid, aIn, bIn, outReady,
    output inReady, outValid, product, busy
  );
endinterface

// File: rtl/multiply_seq_ctrl.sv
// Sequential shift-and-add unsigned multiply controller.
// Accepts an operand pair on a valid/ready handshake, iterates the multiplier
// one bit per slowClk edge, then holds the 2*DATA_WIDTH product on a
// valid/ready output until it is taken. Every output is driven from a register.
// Optional feature: define MULT_EARLY_TERM_EN to finish the iteration as soon
// as the remaining multiplier bits are all zero (same result, shorter latency).
module multiply_seq_ctrl #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                 slowClk,
  input  logic                 reset,
  multiply_seq_ctrl_if.slave   bus
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic [PW-1:0]          product_q;

  logic [PW-1:0]          acc_q;
  logic [PW-1:0]          mcand_q;
  logic [DATA_WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [PW-1:0]          acc_d;
  logic [PW-1:0]          mcand_d;
  logic [DATA_WIDTH-1:0]  mplier_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   last_iter;

  // One partial-product step; the sum wraps modulo 2^PW, which cannot
  // actually happen because an unsigned W x W product always fits in 2W bits.
  function automatic logic [PW-1:0] acc_step(input logic [PW-1:0] acc,
                                             input logic [PW-1:0] mcand,
                                             input logic          mbit);
    return mbit ? (acc + mcand) : acc;
  endfunction

  // Next values of the shift-and-add datapath and the end-of-iteration test.
  always_comb begin
    acc_d     = acc_step(acc_q, mcand_q, mplier_q[0]);
    mcand_d   = mcand_q << 1;
    mplier_d  = mplier_q >> 1;
    cnt_d     = cnt_q + CNT_W'(1);
    last_iter = (cnt_q == CNT_LAST);
`ifdef MULT_EARLY_TERM_EN
    // No set bits left to add: the accumulator already holds the final product.
    last_iter = last_iter | (mplier_d == '0);
`endif
  end

  // Control FSM plus datapath registers; reset overrides every handshake.
  always_ff @(posedge slowClk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inValid && in_ready_q) begin
            mcand_q    <= {{DATA_WIDTH{1'b0}}, bus.aIn};
            mplier_q   <= bus.bIn;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (last_iter) begin
            // product only changes here, so it holds the last result otherwise.
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_valid_q && bus.outReady) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inReady  = in_ready_q;
  assign bus.outValid = out_valid_q;
  assign bus.busy     = busy_q;
  assign bus.product  = product_q;

endmodule
